// File: rtl/d_e_reg.sv
// ---------------------------------------------------------------------------
// d_e_reg -- Decode/Execute pipeline register of the 5-stage MIPS CPU.
//
// Captures the D-stage results for E on every rising clock edge. There is no
// hold mode; D and F are frozen upstream when the pipeline stalls.
// Update priority per edge: reset > req > stall > normal load.
//
// Ports:
//   clk          in   1   system clock, all updates on rising edge
//   reset        in   1   synchronous active-high reset (E_PC <- RESET_PC)
//   req          in   1   CP0 exception/interrupt flush (E_PC <- HANDLER_PC)
//   stall        in   1   hazard bubble; keeps PC/BD, clears everything else
//   D_instr      in   32  decoded instruction word
//   D_PC         in   32  PC of the D-stage instruction
//   D_ext_imm16  in   32  extended immediate
//   D_rs_data    in   32  forwarded rs value
//   D_rt_data    in   32  forwarded rt value
//   D_BD         in   1   instruction sits in a branch delay slot
//   D_ExcCode    in   5   exception code from F/D (0 = none)
//   E_*          out      registered copies of the D_* inputs
//   E_valid      out  1   1 = real instruction, 0 = bubble/flush
// ---------------------------------------------------------------------------
module d_e_reg #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic [31:0] D_instr,
    input  logic [31:0] D_PC,
    input  logic [31:0] D_ext_imm16,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] D_rt_data,
    input  logic        D_BD,
    input  logic [4:0]  D_ExcCode,
    output logic [31:0] E_instr,
    output logic [31:0] E_PC,
    output logic [31:0] E_ext_imm16,
    output logic [31:0] E_rs_data,
    output logic [31:0] E_rt_data,
    output logic        E_BD,
    output logic [4:0]  E_ExcCode,
    output logic        E_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_ext_imm16;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic        r_bd;
    logic [4:0]  r_exc_code;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr     <= '0;
            r_pc        <= RESET_PC;
            r_ext_imm16 <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_bd        <= 1'b0;
            r_exc_code  <= '0;
            r_valid     <= 1'b0;
        end else if (req) begin
            r_instr     <= '0;
            r_pc        <= HANDLER_PC;
            r_ext_imm16 <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_bd        <= 1'b0;
            r_exc_code  <= '0;
            r_valid     <= 1'b0;
        end else if (stall) begin
            // Bubble keeps PC and BD so CP0 still reports the right EPC/BD
            // if an interrupt lands while the bubble travels through E/M.
            r_instr     <= '0;
            r_pc        <= D_PC;
            r_ext_imm16 <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_bd        <= D_BD;
            r_exc_code  <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_instr     <= D_instr;
            r_pc        <= D_PC;
            r_ext_imm16 <= D_ext_imm16;
            r_rs_data   <= D_rs_data;
            r_rt_data   <= D_rt_data;
            r_bd        <= D_BD;
            r_exc_code  <= D_ExcCode;
            r_valid     <= 1'b1;
        end
    end

    assign E_instr     = r_instr;
    assign E_PC        = r_pc;
    assign E_ext_imm16 = r_ext_imm16;
    assign E_rs_data   = r_rs_data;
    assign E_rt_data   = r_rt_data;
    assign E_BD        = r_bd;
    assign E_ExcCode   = r_exc_code;
    assign E_valid     = r_valid;

endmodule

// File: tb/tb_d_e_reg.sv
// ---------------------------------------------------------------------------
// tb_d_e_reg -- self-checking bench for d_e_reg: directed steps followed by
// randomized control/data, compared against a rule-based reference model.
// ---------------------------------------------------------------------------
module tb_d_e_reg;

    logic        clk;
    logic        reset;
    logic        req;
    logic        stall;
    logic [31:0] D_instr;
    logic [31:0] D_PC;
    logic [31:0] D_ext_imm16;
    logic [31:0] D_rs_data;
    logic [31:0] D_rt_data;
    logic        D_BD;
    logic [4:0]  D_ExcCode;
    logic [31:0] E_instr;
    logic [31:0] E_PC;
    logic [31:0] E_ext_imm16;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic        E_BD;
    logic [4:0]  E_ExcCode;
    logic        E_valid;

    int unsigned checks;
    int unsigned errors;

    // expected values, computed before each edge from the applied inputs
    logic [31:0] x_instr, x_pc, x_imm, x_rs, x_rt;
    logic        x_bd, x_valid;
    logic [4:0]  x_exc;

    d_e_reg #(
        .HANDLER_PC (32'h0000_4180),
        .RESET_PC   (32'h0000_3000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .stall       (stall),
        .D_instr     (D_instr),
        .D_PC        (D_PC),
        .D_ext_imm16 (D_ext_imm16),
        .D_rs_data   (D_rs_data),
        .D_rt_data   (D_rt_data),
        .D_BD        (D_BD),
        .D_ExcCode   (D_ExcCode),
        .E_instr     (E_instr),
        .E_PC        (E_PC),
        .E_ext_imm16 (E_ext_imm16),
        .E_rs_data   (E_rs_data),
        .E_rt_data   (E_rt_data),
        .E_BD        (E_BD),
        .E_ExcCode   (E_ExcCode),
        .E_valid     (E_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: an instruction survives only if no control is active; the
    // PC is the reset/handler vector under a clear, otherwise the D PC;
    // BD survives anything except a clear.
    task automatic model();
        logic clear;
        logic live;
        clear   = reset | req;
        live    = !(clear | stall);
        x_valid = live;
        x_instr = live ? D_instr     : 32'h0;
        x_imm   = live ? D_ext_imm16 : 32'h0;
        x_rs    = live ? D_rs_data   : 32'h0;
        x_rt    = live ? D_rt_data   : 32'h0;
        x_exc   = live ? D_ExcCode   : 5'h0;
        x_bd    = clear ? 1'b0 : D_BD;
        x_pc    = reset ? 32'h0000_3000 : (req ? 32'h0000_4180 : D_PC);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // model the applied inputs, clock once, sample 1 time unit after the edge
    task automatic step(input string tag);
        model();
        @(posedge clk);
        #1;
        chk({tag, ".instr"}, E_instr,      x_instr);
        chk({tag, ".pc"},    E_PC,         x_pc);
        chk({tag, ".imm"},   E_ext_imm16,  x_imm);
        chk({tag, ".rs"},    E_rs_data,    x_rs);
        chk({tag, ".rt"},    E_rt_data,    x_rt);
        chk({tag, ".bd"},    {31'h0, E_BD},    {31'h0, x_bd});
        chk({tag, ".exc"},   {27'h0, E_ExcCode}, {27'h0, x_exc});
        chk({tag, ".valid"}, {31'h0, E_valid}, {31'h0, x_valid});
    endtask

    task automatic set_d(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs,
                         input logic [31:0] rt, input logic bd, input logic [4:0] exc);
        D_instr = instr; D_PC = pc; D_ext_imm16 = imm;
        D_rs_data = rs; D_rt_data = rt; D_BD = bd; D_ExcCode = exc;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0; req = 1'b0; stall = 1'b0;
        set_d('0, '0, '0, '0, '0, 1'b0, 5'h0);
        #2;

        // reset with every D input saturated
        reset = 1'b1;
        set_d('1, '1, '1, '1, '1, 1'b1, 5'h1F);
        step("reset");
        // fixed constants for the reset state, independent of the model
        chk("reset.pc_const", E_PC, 32'h0000_3000);
        chk("reset.valid_const", {31'h0, E_valid}, 32'h0);
        reset = 1'b0;

        // normal load
        set_d(32'h3C01_1234, 32'h3004, 32'h1234_0000, 32'd5, 32'd7, 1'b0, 5'd0);
        step("load");
        chk("load.valid_const", {31'h0, E_valid}, 32'h1);

        // stall bubble keeps PC and BD
        set_d(32'h8C22_0004, 32'h3010, 32'h0000_0004, 32'hAAAA_5555, 32'h1357_9BDF, 1'b1, 5'd0);
        stall = 1'b1;
        step("stall");
        chk("stall.pc_const", E_PC, 32'h3010);
        // release: loads normally, no extra bubble
        stall = 1'b0;
        step("unstall");
        chk("unstall.instr_const", E_instr, 32'h8C22_0004);

        // flush overrides stall
        req = 1'b1; stall = 1'b1;
        set_d(32'h0123_4567, 32'h3020, 32'h89AB_CDEF, 32'h1, 32'h2, 1'b1, 5'd4);
        step("flush");
        chk("flush.pc_const", E_PC, 32'h0000_4180);
        req = 1'b0; stall = 1'b0;

        // exception code passes through with valid=1
        set_d(32'h0000_000C, 32'h3030, 32'h0, 32'h0, 32'h0, 1'b0, 5'd10);
        step("exc");
        chk("exc.code_const", {27'h0, E_ExcCode}, 32'd10);

        // reset beats req
        reset = 1'b1; req = 1'b1; stall = 1'b1;
        step("rst_req");
        chk("rst_req.pc_const", E_PC, 32'h0000_3000);
        reset = 1'b0; req = 1'b0; stall = 1'b0;

        // randomized phase: controls biased low so loads dominate
        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 15) == 0);
            req   = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            set_d($urandom, $urandom, $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
